dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 20 ++
 rtl/dmem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared encodings and defaults for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic PORT_MEM = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int DEF_ACCESS_CYCLES = 2;
    localparam int DEF_DEPTH         = 64;

    function automatic logic addr_oor(input logic [31:0] addr, input int depth);
        return addr >= 32'(depth);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational: on a tie the port that
// did not win last time is chosen.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic grant_valid
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant = ~last_grant;
        end else begin
            grant = req1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter/sequencer; ack arrives ACCESS_CYCLES+1 cycles after grant,
// one idle cycle between accesses, port 0 frozen while waiting. Stats via DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH         = DEF_DEPTH,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter int CNT_W         = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        freeze,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_r_en,
    output logic        mem_w_en,
    input  logic [31:0] mem_rdata,
    output logic        err
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0] p0_wait_cnt,
    output logic [31:0] p1_wait_cnt,
    output logic [31:0] conflict_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    state_t            state;
    logic              last_grant;
    logic              gnt;
    logic              lat_we;
    logic              lat_oor;
    logic [CNT_W-1:0]  cnt;

    logic              arb_gnt;
    logic              arb_vld;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_oor;

    rr_arb2 u_rr_arb2 (
        .req0        (p0_req),
        .req1        (p1_req),
        .last_grant  (last_grant),
        .grant       (arb_gnt),
        .grant_valid (arb_vld)
    );

    always_comb begin
        sel_we    = (arb_gnt == PORT_DBG) ? p1_we    : p0_we;
        sel_addr  = (arb_gnt == PORT_DBG) ? p1_addr  : p0_addr;
        sel_wdata = (arb_gnt == PORT_DBG) ? p1_wdata : p0_wdata;
        sel_oor   = addr_oor(sel_addr, DEPTH);
    end

    assign freeze = p0_req & ~p0_ack;

    // mem_addr/mem_wdata are the latched request copies, so late changes on
    // the requester side cannot disturb an access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= PORT_DBG;
            gnt        <= PORT_MEM;
            lat_we     <= 1'b0;
            lat_oor    <= 1'b0;
            cnt        <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_r_en   <= 1'b0;
            mem_w_en   <= 1'b0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            err        <= 1'b0;
        end else begin
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            err      <= 1'b0;
            mem_w_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arb_vld) begin
                        gnt        <= arb_gnt;
                        last_grant <= arb_gnt;
                        lat_we     <= sel_we;
                        lat_oor    <= sel_oor;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        cnt        <= '0;
                        mem_r_en   <= ~sel_we & ~sel_oor;
                        mem_w_en   <= sel_we & ~sel_oor;
                        state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        mem_r_en <= 1'b0;
                        err      <= lat_oor;
                        state    <= S_DONE;
                        if (gnt == PORT_MEM) begin
                            p0_ack <= 1'b1;
                            if (lat_oor) begin
                                p0_rdata <= '0;
                            end else if (!lat_we) begin
                                p0_rdata <= mem_rdata;
                            end
                        end else begin
                            p1_ack <= 1'b1;
                            if (lat_oor) begin
                                p1_rdata <= '0;
                            end else if (!lat_we) begin
                                p1_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // In IDLE no port owns the memory, so any raised request counts as waiting.
    logic p0_waiting;
    logic p1_waiting;

    assign p0_waiting = p0_req & ~((state != S_IDLE) && (gnt == PORT_MEM));
    assign p1_waiting = p1_req & ~((state != S_IDLE) && (gnt == PORT_DBG));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0_wait_cnt  <= '0;
            p1_wait_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            if (p0_waiting && (p0_wait_cnt != '1)) begin
                p0_wait_cnt <= p0_wait_cnt + 1'b1;
            end
            if (p1_waiting && (p1_wait_cnt != '1)) begin
                p1_wait_cnt <= p1_wait_cnt + 1'b1;
            end
            if ((state == S_IDLE) && p0_req && p1_req && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed stimulus for dmem_arbiter against a transaction-level reference.
module tb_dmem_arbiter;

    localparam int AC    = 2;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];

    logic        p0_ack, p1_ack, freeze, mem_r_en, mem_w_en, err;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] p0_wait_cnt, p1_wait_cnt, conflict_cnt;
`endif

    logic [31:0] tb_mem [DEPTH] = '{default: '0};

    dmem_arbiter #(.DEPTH(DEPTH), .ACCESS_CYCLES(AC), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_req    (req[0]),
        .p0_we     (we[0]),
        .p0_addr   (addr[0]),
        .p0_wdata  (wdata[0]),
        .p0_ack    (p0_ack),
        .p0_rdata  (p0_rdata),
        .p1_req    (req[1]),
        .p1_we     (we[1]),
        .p1_addr   (addr[1]),
        .p1_wdata  (wdata[1]),
        .p1_ack    (p1_ack),
        .p1_rdata  (p1_rdata),
        .freeze    (freeze),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_r_en  (mem_r_en),
        .mem_w_en  (mem_w_en),
        .mem_rdata (mem_rdata),
        .err       (err)
`ifdef DMEM_ARB_STATS_EN
        ,
        .p0_wait_cnt  (p0_wait_cnt),
        .p1_wait_cnt  (p1_wait_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural memory; out-of-range reads return a marker that must never reach rdata.
    assign mem_rdata = (mem_addr < DEPTH) ? tb_mem[mem_addr[5:0]] : 32'hBAD0_0BAD;
    always @(posedge clk) begin
        if (mem_w_en && (mem_addr < DEPTH)) tb_mem[mem_addr[5:0]] <= mem_wdata;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: one transaction at a time, tracked as "cycles since grant".
    int          m_phase = 0;
    bit          m_port = 1'b0;
    bit          m_last = 1'b1;
    bit          m_we = 1'b0;
    bit          m_oor = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata [2] = '{default: '0};
    logic [31:0] ref_mem [DEPTH] = '{default: '0};
    int          st_wait [2] = '{default: 0};
    int          st_conf = 0;
    int          n_wen = 0;
    int          n_ren = 0;

    task automatic cycle();
        logic [1:0]  s_req, s_we, e_ack;
        logic [31:0] s_addr [2];
        logic [31:0] s_wdata [2];
        logic        s_rst, e_err, e_r, e_w;
        s_req = req; s_we = we; s_rst = rst_n;
        for (int p = 0; p < 2; p++) begin
            s_addr[p] = addr[p];
            s_wdata[p] = wdata[p];
        end
        @(posedge clk);
        #1;
        e_ack = '0;
        e_err = 1'b0;
        if (!s_rst) begin
            m_phase = 0; m_last = 1'b1;
            m_rdata[0] = '0; m_rdata[1] = '0;
            st_wait[0] = 0; st_wait[1] = 0; st_conf = 0;
        end else begin
            for (int p = 0; p < 2; p++)
                if (s_req[p] && !(m_phase != 0 && int'(m_port) == p)) st_wait[p]++;
            if (m_phase == 0 && (&s_req)) st_conf++;
            if (m_phase == 0) begin
                if (|s_req) begin
                    m_port  = (&s_req) ? ~m_last : s_req[1];
                    m_last  = m_port;
                    m_we    = s_we[m_port];
                    m_addr  = s_addr[m_port];
                    m_wdata = s_wdata[m_port];
                    m_oor   = m_addr >= DEPTH;
                    if (m_we && !m_oor) ref_mem[m_addr[5:0]] = m_wdata;
                    m_phase = 1;
                end
            end else if (m_phase == AC) begin
                m_phase = AC + 1;
                e_ack[m_port] = 1'b1;
                e_err = m_oor;
                if (m_oor) m_rdata[m_port] = '0;
                else if (!m_we) m_rdata[m_port] = ref_mem[m_addr[5:0]];
            end else if (m_phase == AC + 1) begin
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end
        e_r = (m_phase >= 1) && (m_phase <= AC) && !m_we && !m_oor;
        e_w = (m_phase == 1) && m_we && !m_oor;
        if (mem_w_en) n_wen++;
        if (mem_r_en) n_ren++;
        chk("p0_ack", p0_ack, e_ack[0]);
        chk("p1_ack", p1_ack, e_ack[1]);
        chk("err", err, e_err);
        chk("mem_r_en", mem_r_en, e_r);
        chk("mem_w_en", mem_w_en, e_w);
        chk("p0_rdata", p0_rdata, m_rdata[0]);
        chk("p1_rdata", p1_rdata, m_rdata[1]);
        chk("freeze", freeze, s_req[0] & ~e_ack[0]);
        if (!s_rst) begin
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
        end
        if (e_r || e_w) chk("mem_addr", mem_addr, m_addr);
        if (e_w) chk("mem_wdata", mem_wdata, m_wdata);
`ifdef DMEM_ARB_STATS_EN
        chk("p0_wait_cnt", p0_wait_cnt, st_wait[0]);
        chk("p1_wait_cnt", p1_wait_cnt, st_wait[1]);
        chk("conflict_cnt", conflict_cnt, st_conf);
`endif
    endtask

    task automatic wait_ack(input int p, output int lat);
        logic seen;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            cycle();
            lat++;
            seen = (p == 0) ? p0_ack : p1_ack;
        end
        req[p] = 1'b0;
        chk("ack_seen", seen, 1'b1);
    endtask

    function automatic logic [31:0] rnd_addr();
        int k;
        k = int'($urandom % 16);
        if (k == 0) return 32'(DEPTH) + ($urandom % 4);
        if (k == 1) return $urandom;
        return $urandom % 8;
    endfunction

    initial begin
        int lat;
        int order [$];
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;

        rst_n = 1'b0;
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();

        // Port 0 write then read back at address 5.
        n_wen = 0;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd5; wdata[0] = 32'hDEADBEEF;
        wait_ack(0, lat);
        chk("t1_latency", lat, AC + 1);
        chk("t1_write_count", n_wen, 1);
        cycle();
        n_ren = 0;
        req[0] = 1'b1; we[0] = 1'b0;
        wait_ack(0, lat);
        chk("t2_latency", lat, AC + 1);
        chk("t2_rdata", p0_rdata, 32'hDEADBEEF);
        chk("t2_read_cycles", n_ren, AC);
        chk("t2_err", err, 1'b0);

        // Both ports held from reset: strict alternation starting with port 0.
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        req = 2'b11; we = 2'b00; addr[0] = 32'd5; addr[1] = 32'd3;
        for (int i = 0; i < 40 && order.size() < 4; i++) begin
            cycle();
            if (p0_ack) order.push_back(0);
            if (p1_ack) order.push_back(1);
        end
        req = 2'b00;
        chk("t3_ack_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) chk("t3_order", order[i], i % 2);
        cycle(); cycle();

        // Port 1 out-of-range read.
        n_wen = 0; n_ren = 0;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'd64;
        wait_ack(1, lat);
        chk("t4_latency", lat, AC + 1);
        chk("t4_err", err, 1'b1);
        chk("t4_rdata", p1_rdata, 32'h0);
        chk("t4_no_enables", n_wen + n_ren, 0);
        cycle();

        // Reset during the last ACCESS cycle of a port 0 read, then re-issue.
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'd5;
        cycle(); cycle();
        rst_n = 1'b0;
        cycle();
        chk("t5_no_ack", p0_ack, 1'b0);
        chk("t5_r_en", mem_r_en, 1'b0);
        rst_n = 1'b1;
        wait_ack(0, lat);
        chk("t5_reissue_latency", lat, AC + 1);
        chk("t5_rdata", p0_rdata, 32'hDEADBEEF);

        // Randomized traffic with occasional drops, field churn and resets.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom % 200) != 0;
            cycle();
            for (int p = 0; p < 2; p++) begin
                if (req[p] && ((p == 0) ? p0_ack : p1_ack)) begin
                    req[p] = 1'b0;
                end else if (req[p] && ($urandom % 32 == 0)) begin
                    req[p] = 1'b0;
                end else if (!req[p] && ($urandom % 3 == 0)) begin
                    req[p] = 1'b1;
                    we[p] = $urandom % 2;
                    addr[p] = rnd_addr();
                    wdata[p] = $urandom;
                end
                if ($urandom % 8 == 0) begin
                    addr[p] = rnd_addr();
                    wdata[p] = $urandom;
                end
            end
        end
        rst_n = 1'b1;
        req = 2'b00;
        cycle(); cycle(); cycle(); cycle();

`ifdef DMEM_ARB_STATS_EN
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        req = 2'b11; we = 2'b00;
        for (int i = 0; i < 10; i++) cycle();
        chk("t6_conflict_cnt", conflict_cnt, st_conf);
        chk("t6_p1_wait_cnt", p1_wait_cnt, st_wait[1]);
        req = 2'b00;
        cycle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
